// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses IM combinationally and
// latches the returned word into IF/ID, sequencing boot, stall, redirect and halt.
`timescale 1ns/1ps

// state    | meaning
// S_BOOT   | one idle edge after reset release, nothing latched
// S_RUN    | fetching one word per edge
// S_HOLD   | stalled by the hazard unit, PC and IF/ID frozen
// S_HALTED | fetch stopped until the next reset
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Halt,
    output logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] InstructionIn,
    output logic [DATA_W-1:0] IFID_Instruction,
    output logic [ADDR_W-1:0] IFID_PCPlus1,
    output logic              IFID_Valid,
    output logic [ADDR_W-1:0] PC,
    output logic              Halted,
    output logic [15:0]       FetchCount
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_fetch;
    logic              w_redirect;
    logic              w_flush;
    logic [ADDR_W-1:0] w_pc_inc;

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ifid_instr;
    logic [ADDR_W-1:0] r_ifid_pcp1;
    logic              r_ifid_valid;
    logic              r_halted;
    logic [15:0]       r_fetch_count;

    assign w_pc_inc = r_pc + PC_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority in RUN/HOLD: Halt > BranchTaken > Stall > fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        w_redirect  = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_BOOT: begin
                if (Halt) begin
                    w_state_nxt = S_HALTED;
                    w_flush     = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN, S_HOLD: begin
                if (Halt) begin
                    w_state_nxt = S_HALTED;
                    w_flush     = 1'b1;
                end else if (BranchTaken) begin
                    w_state_nxt = S_RUN;
                    w_redirect  = 1'b1;
                end else if (Stall) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_RUN;
                    w_fetch     = 1'b1;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_ifid_instr  <= NOP_WORD;
            r_ifid_pcp1   <= '0;
            r_ifid_valid  <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= 16'd0;
        end else begin
            r_halted <= (w_state_nxt == S_HALTED);
            if (w_fetch) begin
                r_pc         <= w_pc_inc;
                r_ifid_instr <= InstructionIn;
                r_ifid_pcp1  <= w_pc_inc;
                r_ifid_valid <= 1'b1;
                if (r_fetch_count != 16'hFFFF) begin
                    r_fetch_count <= r_fetch_count + 16'd1;
                end
            end else if (w_redirect) begin
                r_pc         <= BranchTarget;
                r_ifid_instr <= NOP_WORD;
                r_ifid_valid <= 1'b0;
            end else if (w_flush) begin
                r_ifid_instr <= NOP_WORD;
                r_ifid_valid <= 1'b0;
            end
        end
    end

    assign Address          = r_pc;
    assign PC               = r_pc;
    assign IFID_Instruction = r_ifid_instr;
    assign IFID_PCPlus1     = r_ifid_pcp1;
    assign IFID_Valid       = r_ifid_valid;
    assign Halted           = r_halted;
    assign FetchCount       = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan sequence, random traffic and
// FetchCount saturation, all checked against a behavioural fetch model.
`timescale 1ns/1ps

module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall;
    logic        BranchTaken;
    logic [7:0]  BranchTarget;
    logic        Halt;
    logic [7:0]  Address;
    logic [31:0] InstructionIn;
    logic [31:0] IFID_Instruction;
    logic [7:0]  IFID_PCPlus1;
    logic        IFID_Valid;
    logic [7:0]  PC;
    logic        Halted;
    logic [15:0] FetchCount;

    logic [31:0] im [256];

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model: only "booting" and "halted" matter; RUN and HOLD act alike
    logic [7:0]  m_pc;
    logic [31:0] m_ifid;
    logic [7:0]  m_pcp1;
    logic        m_valid;
    logic        m_halted;
    logic        m_booting;
    logic [15:0] m_count;

    fetch_sequencer #(
        .ADDR_W(8), .DATA_W(32), .RESET_PC(8'd0), .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Halt(Halt), .Address(Address),
        .InstructionIn(InstructionIn), .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus1(IFID_PCPlus1), .IFID_Valid(IFID_Valid), .PC(PC),
        .Halted(Halted), .FetchCount(FetchCount)
    );

    always #5 clk = ~clk;

    assign InstructionIn = im[Address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 8'd0;
        m_ifid    = 32'h0;
        m_pcp1    = 8'd0;
        m_valid   = 1'b0;
        m_halted  = 1'b0;
        m_booting = 1'b1;
        m_count   = 16'd0;
    endtask

    task automatic model_edge(input logic s, input logic b, input logic [7:0] t, input logic h);
        if (m_booting) begin
            m_booting = 1'b0;
            if (h) begin
                m_halted = 1'b1;
                m_ifid   = 32'h0;
                m_valid  = 1'b0;
            end
        end else if (m_halted) begin
            // frozen until reset
        end else if (h) begin
            m_halted = 1'b1;
            m_ifid   = 32'h0;
            m_valid  = 1'b0;
        end else if (b) begin
            m_pc    = t;
            m_ifid  = 32'h0;
            m_valid = 1'b0;
        end else if (!s) begin
            m_ifid  = im[m_pc];
            m_pcp1  = 8'((int'(m_pc) + 1) % 256);
            m_pc    = m_pcp1;
            m_valid = 1'b1;
            if (m_count < 16'hFFFF) m_count = m_count + 16'd1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},    {24'h0, PC},              {24'h0, m_pc});
        check({tag, ".addr"},  {24'h0, Address},         {24'h0, m_pc});
        check({tag, ".ifid"},  IFID_Instruction,         m_ifid);
        check({tag, ".pcp1"},  {24'h0, IFID_PCPlus1},    {24'h0, m_pcp1});
        check({tag, ".valid"}, {31'h0, IFID_Valid},      {31'h0, m_valid});
        check({tag, ".halt"},  {31'h0, Halted},          {31'h0, m_halted});
        check({tag, ".count"}, {16'h0, FetchCount},      {16'h0, m_count});
    endtask

    // called #1 after an edge; reset pulse lands and releases before the next edge
    task automatic async_reset(input string tag);
        Stall = 1'b0; BranchTaken = 1'b0; Halt = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step(input string tag, input logic s, input logic b,
                        input logic [7:0] t, input logic h);
        Stall = s; BranchTaken = b; BranchTarget = t; Halt = h;
        model_edge(s, b, t, h);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) im[i] = 32'h1000_0000 + i;
        Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 8'd0; Halt = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all("reset");
        #1 rst_n = 1'b1;

        // boot then free-run
        step("boot", 1'b0, 1'b0, 8'd0, 1'b0);
        check("boot.valid_const", {31'h0, IFID_Valid}, 32'd0);
        step("run1", 1'b0, 1'b0, 8'd0, 1'b0);
        check("run1.ifid_const", IFID_Instruction, 32'h1000_0000);
        check("run1.pcp1_const", {24'h0, IFID_PCPlus1}, 32'd1);
        repeat (3) step("run", 1'b0, 1'b0, 8'd0, 1'b0);
        check("run4.pc_const", {24'h0, PC}, 32'd4);
        check("run4.count_const", {16'h0, FetchCount}, 32'd4);
        step("run5", 1'b0, 1'b0, 8'd0, 1'b0);

        // stall at PC = 5, then release
        repeat (3) step("stall", 1'b1, 1'b0, 8'd0, 1'b0);
        check("stall.ifid_const", IFID_Instruction, 32'h1000_0004);
        step("unstall", 1'b0, 1'b0, 8'd0, 1'b0);
        check("unstall.ifid_const", IFID_Instruction, 32'h1000_0005);
        check("unstall.pc_const", {24'h0, PC}, 32'd6);
        step("run7", 1'b0, 1'b0, 8'd0, 1'b0);

        // branch overrides stall, one bubble
        step("br20", 1'b1, 1'b1, 8'd20, 1'b0);
        check("br20.pc_const", {24'h0, PC}, 32'd20);
        step("br20.next", 1'b0, 1'b0, 8'd0, 1'b0);
        check("br20.ifid_const", IFID_Instruction, 32'h1000_0014);

        // PC wrap
        step("br254", 1'b0, 1'b1, 8'd254, 1'b0);
        step("wrap255", 1'b0, 1'b0, 8'd0, 1'b0);
        step("wrap0", 1'b0, 1'b0, 8'd0, 1'b0);
        check("wrap0.pcp1_const", {24'h0, IFID_PCPlus1}, 32'd0);
        step("wrap1", 1'b0, 1'b0, 8'd0, 1'b0);
        check("wrap1.pc_const", {24'h0, PC}, 32'd1);

        // halt beats branch, then everything is ignored
        step("br40", 1'b0, 1'b1, 8'd40, 1'b0);
        step("halt", 1'b0, 1'b1, 8'd9, 1'b1);
        check("halt.pc_const", {24'h0, PC}, 32'd40);
        step("halt.stall", 1'b1, 1'b0, 8'd0, 1'b0);
        step("halt.br", 1'b0, 1'b1, 8'd77, 1'b0);
        step("halt.idle", 1'b0, 1'b0, 8'd0, 1'b0);

        // reset mid-run at PC = 42
        async_reset("rst_halt");
        step("boot2", 1'b1, 1'b1, 8'd99, 1'b0);
        step("br41", 1'b0, 1'b1, 8'd41, 1'b0);
        step("run42", 1'b0, 1'b0, 8'd0, 1'b0);
        async_reset("rst42");
        check("rst42.pc_const", {24'h0, PC}, 32'd0);
        step("boot3", 1'b0, 1'b0, 8'd0, 1'b0);
        step("resume", 1'b0, 1'b0, 8'd0, 1'b0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
                async_reset("rnd.rst");
            end else begin
                step("rnd",
                     ($urandom_range(0, 99) < 25),
                     ($urandom_range(0, 99) < 10),
                     8'($urandom_range(0, 255)),
                     ($urandom_range(0, 199) < 2));
            end
        end

        // FetchCount saturation
        async_reset("sat.rst");
        BranchTaken = 1'b0; Stall = 1'b0; Halt = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            model_edge(1'b0, 1'b0, 8'd0, 1'b0);
            @(posedge clk);
        end
        #1;
        compare_all("sat");
        check("sat.count_const", {16'h0, FetchCount}, 32'h0000_FFFF);
        step("sat.more", 1'b0, 1'b0, 8'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
